// File: rtl/obi_wb_pkg.sv
// Shared types and constants for the OBI-to-Wishbone bridge.
package obi_wb_pkg;

  // Default number of Wishbone cycles allowed before a transfer is aborted.
  localparam int TIMEOUT_DEFAULT = 255;

  // Bridge FSM: accept on the OBI side, run the Wishbone cycle, then respond.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/obi_wb_timeout.sv
// Wishbone watchdog for the OBI-to-Wishbone bridge. It is only instantiated
// when OBI_WB_TIMEOUT_EN is defined. It counts BUS cycles and flags the cycle
// that is the TIMEOUT_CYCLES-th one spent waiting for the slave.
module obi_wb_timeout
  import obi_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,   // request granted: BUS is entered next cycle
  input  logic busy_i,    // bridge is in BUS this cycle
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  // Number of BUS cycles already completed for the current transfer.
  logic [CW-1:0] cnt_q;

  // The current cycle is the TIMEOUT_CYCLES-th BUS cycle.
  assign expired_o = busy_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Counter: clears on grant and advances once per BUS cycle.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= '0;
    end else if (busy_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/obi_wb_bridge.sv
// OBI data-port slave to Wishbone classic master bridge. It handles one
// outstanding transfer at a time. Optional feature: define OBI_WB_TIMEOUT_EN
// to abort a Wishbone cycle after TIMEOUT_CYCLES cycles without ack/err.
module obi_wb_bridge
  import obi_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // OBI side
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [3:0]            data_be_i,
  input  logic                  data_we_i,
  input  logic [31:0]           data_wdata_i,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  // Wishbone classic master side
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("obi_wb_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [3:0]            sel_q;
  logic                  we_q;
  logic [31:0]           dat_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  timeout;
  logic                  bus_done;
  logic                  bus_fault;

`ifdef OBI_WB_TIMEOUT_EN
  obi_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (data_gnt_o),
    .busy_i   (state_q == BUS),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Accept only when idle, so at most one transfer is ever in flight.
  assign data_gnt_o = data_req_i && (state_q == IDLE);

  // A real slave answer takes priority over the watchdog, and err beats ack.
  assign bus_done  = wb_ack_i || wb_err_i || timeout;
  assign bus_fault = wb_err_i || (timeout && !wb_ack_i);

  assign wb_cyc_o      = (state_q == BUS);
  assign wb_stb_o      = (state_q == BUS);
  assign wb_we_o       = we_q;
  assign wb_adr_o      = adr_q;
  assign wb_sel_o      = sel_q;
  assign wb_dat_o      = dat_q;
  assign data_rvalid_o = (state_q == RESP);
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

  // Next-state logic; ack/err only matter while in BUS.
  // NOTE: state_d gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (data_gnt_o) state_d = BUS;
      BUS:     if (bus_done)   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Request capture on grant; held stable for the whole Wishbone cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      adr_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      dat_q <= '0;
    end else if (data_gnt_o) begin
      adr_q <= data_addr_i;
      sel_q <= data_be_i;
      we_q  <= data_we_i;
      dat_q <= data_wdata_i;
    end
  end

  // Response capture at termination; values hold until the next response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if ((state_q == BUS) && bus_done) begin
      err_q   <= bus_fault;
      rdata_q <= (bus_fault || we_q) ? 32'h0 : wb_dat_i;
    end
  end

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Self-checking bench for obi_wb_bridge: directed OBI requests against a
// simple Wishbone slave model. Expected responses go into a scoreboard queue,
// and a monitor compares them on every rvalid.
module tb_obi_wb_bridge;

  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk_i;
  logic          rst_ni;
  logic          data_req_i;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [AW-1:0] data_addr_i;
  logic [3:0]    data_be_i;
  logic          data_we_i;
  logic [31:0]   data_wdata_i;
  logic [31:0]   data_rdata_o;
  logic          data_err_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [3:0]    wb_sel_o;
  logic [31:0]   wb_dat_o;
  logic [31:0]   wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;

  obi_wb_bridge #(
    .TIMEOUT_CYCLES(TO),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .data_req_i   (data_req_i),
    .data_gnt_o   (data_gnt_o),
    .data_rvalid_o(data_rvalid_o),
    .data_addr_i  (data_addr_i),
    .data_be_i    (data_be_i),
    .data_we_i    (data_we_i),
    .data_wdata_i (data_wdata_i),
    .data_rdata_o (data_rdata_o),
    .data_err_o   (data_err_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_adr_o     (wb_adr_o),
    .wb_sel_o     (wb_sel_o),
    .wb_dat_o     (wb_dat_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t         exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc_no = 0;
  int            rv_count = 0;
  int            rv_hist[$];
  int            bus_cycles = 0;
  logic [AW-1:0] exp_adr = '0;
  logic [3:0]    exp_sel = '0;
  logic          exp_we = 1'b0;
  logic [31:0]   exp_dat = '0;

  // Slave model controls.
  int          slave_wait = 0;
  logic        slave_ack  = 1'b1;
  logic        slave_err  = 1'b0;
  logic        slave_en   = 1'b1;
  logic        stray      = 1'b0;
  logic [31:0] slave_data = '0;
  int          stb_cnt    = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc_no++;
  end

  // Wishbone slave: answers slave_wait cycles after stb first rises.
  // With stray set, it also pulses ack/err while no cycle is open.
  initial begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = '0;
      if (wb_cyc_o && wb_stb_o) begin
        if (slave_en && stb_cnt == slave_wait) begin
          wb_ack_i = slave_ack;
          wb_err_i = slave_err;
          wb_dat_i = slave_data;
        end
        stb_cnt++;
      end else begin
        stb_cnt = 0;
        if (stray) begin
          wb_ack_i = 1'b1;
          wb_err_i = 1'b1;
          wb_dat_i = 32'h5555_5555;
        end
      end
    end
  end

  // Monitor: grant legality, Wishbone request contents, scoreboard on rvalid.
  initial forever begin
    resp_t e;
    @(negedge clk_i);
    if (data_gnt_o === 1'b1)
      check("gnt_while_busy", {62'h0, wb_cyc_o, data_rvalid_o}, 64'h0);
    if (wb_cyc_o === 1'b1) begin
      bus_cycles++;
      check("bus_stb", wb_stb_o, 64'h1);
      check("bus_adr", wb_adr_o, exp_adr);
      check("bus_sel", wb_sel_o, exp_sel);
      check("bus_we",  wb_we_o,  exp_we);
      check("bus_dat", wb_dat_o, exp_dat);
    end
    if (data_rvalid_o === 1'b1) begin
      rv_count++;
      rv_hist.push_back(cyc_no);
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", data_rvalid_o, 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", data_rdata_o, e.rdata);
        check("resp_err",   data_err_o,   e.err);
      end
    end
  end

  // Raise a request and hold it until granted; the scoreboard entry is pushed
  // on grant. The request stays asserted on return so requests can chain.
  task automatic issue(input logic [AW-1:0] a, input logic [3:0] be,
                       input logic we, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_er,
                       output int g_cyc);
    resp_t r;
    int    n;
    n     = 0;
    g_cyc = -1;
    @(posedge clk_i);
    #1;
    data_req_i   = 1'b1;
    data_addr_i  = a;
    data_be_i    = be;
    data_we_i    = we;
    data_wdata_i = wd;
    while (n < 100) begin
      @(negedge clk_i);
      if (data_gnt_o === 1'b1) begin
        g_cyc   = cyc_no;
        exp_adr = a;
        exp_sel = be;
        exp_we  = we;
        exp_dat = wd;
        r.rdata = exp_rd;
        r.err   = exp_er;
        exp_q.push_back(r);
        break;
      end
      n++;
    end
    if (g_cyc < 0) check("grant_timeout", data_gnt_o, 64'h1);
  endtask

  task automatic drop_req();
    @(posedge clk_i);
    #1;
    data_req_i = 1'b0;
  endtask

  task automatic wait_rv(input int target);
    int n;
    n = 0;
    while (rv_count < target && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (rv_count < target) check("rvalid_timeout", rv_count, target);
  endtask

  function automatic int last_rv();
    return rv_hist[rv_hist.size() - 1];
  endfunction

  int g1, g2, r1, r2;

  initial begin
    rst_ni       = 1'b0;
    data_req_i   = 1'b0;
    data_addr_i  = '0;
    data_be_i    = '0;
    data_we_i    = 1'b0;
    data_wdata_i = '0;

    // Reset state.
    #2;
    check("rst_gnt",    data_gnt_o,    64'h0);
    check("rst_rvalid", data_rvalid_o, 64'h0);
    check("rst_rdata",  data_rdata_o,  64'h0);
    check("rst_err",    data_err_o,    64'h0);
    check("rst_cyc",    wb_cyc_o,      64'h0);
    check("rst_stb",    wb_stb_o,      64'h0);
    check("rst_wb_out", {wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} == '0, 64'h1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Read, slave acks 3 cycles after stb: grant N, stb N+1, ack N+4, rvalid N+5.
    slave_wait = 3; slave_ack = 1'b1; slave_err = 1'b0; slave_data = 32'hCAFE_F00D;
    issue(32'h0000_1000, 4'hF, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, g1);
    drop_req();
    wait_rv(1);
    check("read_latency", last_rv() - g1, 64'd5);

    // Stray ack/err while idle must be ignored, and the response must hold.
    @(negedge clk_i);
    stray = 1'b1;
    repeat (3) @(negedge clk_i);
    stray = 1'b0;
    repeat (2) @(negedge clk_i);
    check("stray_no_rvalid", rv_count, 64'd1);
    check("hold_rdata", data_rdata_o, 64'hCAFE_F00D);
    check("hold_err",   data_err_o,   64'h0);

    // Write with partial byte enables: rdata returns 0.
    slave_wait = 1; slave_data = 32'hFFFF_FFFF;
    issue(32'h0000_0020, 4'b0011, 1'b1, 32'h1234_5678, 32'h0, 1'b0, g1);
    drop_req();
    wait_rv(2);

    // Ack and err together on a read: err wins, rdata cleared.
    slave_wait = 0; slave_err = 1'b1; slave_data = 32'hDEAD_BEEF;
    issue(32'h0000_0044, 4'hF, 1'b0, 32'h0, 32'h0, 1'b1, g1);
    drop_req();
    wait_rv(3);
    slave_err = 1'b0;

    // Back-to-back zero-wait reads with the request held high.
    slave_wait = 0; slave_data = 32'h1357_9BDF;
    issue(32'h0000_0100, 4'hF, 1'b0, 32'hAAAA_0001, 32'h1357_9BDF, 1'b0, g1);
    issue(32'h0000_0104, 4'hF, 1'b0, 32'hAAAA_0002, 32'h1357_9BDF, 1'b0, g2);
    drop_req();
    wait_rv(5);
    r1 = rv_hist[3];
    r2 = rv_hist[4];
    check("b2b_lat1", r1 - g1, 64'd2);
    check("b2b_gap",  g2 - r1, 64'd1);
    check("b2b_lat2", r2 - g2, 64'd2);

    // Reset in the middle of BUS: aborts immediately, no rvalid.
    slave_wait = 20; slave_data = 32'h0BAD_0BAD;
    issue(32'h0000_0200, 4'hF, 1'b0, 32'h0, 32'h0BAD_0BAD, 1'b0, g1);
    drop_req();
    repeat (2) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("abort_cyc",    wb_cyc_o,      64'h0);
    check("abort_stb",    wb_stb_o,      64'h0);
    check("abort_rvalid", data_rvalid_o, 64'h0);
    check("abort_adr",    wb_adr_o,      64'h0);
    check("abort_rdata",  data_rdata_o,  64'h0);
    exp_q.delete();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (25) @(negedge clk_i);
    check("abort_no_rvalid", rv_count, 64'd5);

    // Normal read after release.
    slave_wait = 0; slave_data = 32'hA5A5_0001;
    issue(32'h0000_0300, 4'hF, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0, g1);
    drop_req();
    wait_rv(6);
    check("post_rst_latency", last_rv() - g1, 64'd2);

`ifdef OBI_WB_TIMEOUT_EN
    // Slave never answers: cyc held for exactly TO cycles, then error response.
    slave_en = 1'b0;
    @(negedge clk_i);
    bus_cycles = 0;
    issue(32'h0000_0400, 4'hF, 1'b0, 32'h0, 32'h0, 1'b1, g1);
    drop_req();
    wait_rv(7);
    check("timeout_bus_cycles", bus_cycles, TO);
    check("timeout_latency", last_rv() - g1, TO + 1);
    slave_en = 1'b1;
`endif

    repeat (5) @(negedge clk_i);
    check("scoreboard_empty", exp_q.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
